lsf_histogram_accum: RTL

//  Parametrised r-bin histogram accumulator for the LSF segment finder. Counts hits per r-bin

---
 rtl/lsf_histogram_accum_if.sv | 24 ++
 rtl/lsf_histogram_accum.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lsf_histogram_accum_if.sv
// Bin-index AXI-stream carried into the LSF histogram accumulator.
//   bin_tdata  : bin word, MSB = invalid flag, lower bits = bin index
//   bin_tvalid : bin word valid (driven by the producer)
//   bin_tready : accept (driven by the accumulator)
// master = producer side, slave = accumulator side.
interface lsf_histogram_accum_if #(
  parameter int unsigned BIN_W = 8
) ();
  logic [BIN_W-1:0] bin_tdata;
  logic             bin_tvalid;
  logic             bin_tready;

  modport master (
    output bin_tdata,
    output bin_tvalid,
    input  bin_tready
  );

  modport slave (
    input  bin_tdata,
    input  bin_tvalid,
    output bin_tready
  );
endinterface

// File: rtl/lsf_histogram_accum.sv
// R-bin histogram accumulator for the LSF segment finder.
// Counts hits per bin from a stream of bin indices, tracks the running maximum and reports the
// winning bin once per event. Bins are zeroed by a one-bin-per-cycle clear sweep.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bin_if         slave stream of bin words (tdata/tvalid in, tready out)
//   enable         global stall; low freezes pipeline, sweep and FSM
//   event_done     end-of-event pulse (honoured in ACCUM only)
//   clear_req      abort and restart the clear sweep
//   clear_busy     clear sweep in progress
//   max_bin/count  running maximum, max_vld pulses on each update
//   result_*       per-event winner, result_vld pulses once per event
module lsf_histogram_accum #(
  parameter int unsigned NBINS      = 128,
  parameter int unsigned BIN_W      = 8,
  parameter int unsigned CNT_W      = 4,
  parameter bit          AUTO_CLEAR = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lsf_histogram_accum_if.slave   bin_if,
  input  logic                   enable,
  input  logic                   event_done,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic [BIN_W-2:0]       max_bin,
  output logic [CNT_W-1:0]       max_count,
  output logic                   max_vld,
  output logic                   result_vld,
  output logic [BIN_W-2:0]       result_bin,
  output logic [CNT_W-1:0]       result_count
);

  localparam int unsigned AW = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StClear, StAccum, StDrain, StReport} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_addr_q, clr_addr_d;
  logic             s1_vld_q, s1_vld_d;
  logic [AW-1:0]    s1_idx_q, s1_idx_d;
  logic             s2_vld_q, s2_vld_d;
  logic [AW-1:0]    s2_idx_q, s2_idx_d;
  logic [CNT_W-1:0] s2_cnt_q, s2_cnt_d;
  logic [BIN_W-2:0] max_bin_q, max_bin_d;
  logic [CNT_W-1:0] max_count_q, max_count_d;
  logic             max_vld_q, max_vld_d;

  logic [CNT_W-1:0] mem [NBINS];

  logic [BIN_W-2:0] beat_idx;
  logic             beat_ok;
  logic             accept;
  logic [CNT_W-1:0] s3_cnt;
  logic             s3_bump;
  logic             s3_we;
  logic [CNT_W-1:0] rd_fwd;

  assign beat_idx = bin_if.bin_tdata[BIN_W-2:0];
  assign beat_ok  = ~bin_if.bin_tdata[BIN_W-1] && (32'(beat_idx) < NBINS);
  assign accept   = (state_q == StAccum) && enable && bin_if.bin_tvalid;

  // S3: saturating increment; a saturated re-hit never moves the running max.
  assign s3_cnt  = (s2_cnt_q == CntMax) ? CntMax : s2_cnt_q + CNT_W'(1);
  assign s3_bump = s2_vld_q && (s2_cnt_q != CntMax) && (s3_cnt > max_count_q);
  assign s3_we   = enable && s2_vld_q && !clear_req;

  // S2 read: the S3 write lands on the same edge, so forward it when the indices collide.
  // Writes from earlier edges are already visible in the array.
  assign rd_fwd = (s2_vld_q && (s2_idx_q == s1_idx_q)) ? s3_cnt : mem[s1_idx_q];

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    s1_vld_d    = s1_vld_q;
    s1_idx_d    = s1_idx_q;
    s2_vld_d    = s2_vld_q;
    s2_idx_d    = s2_idx_q;
    s2_cnt_d    = s2_cnt_q;
    max_bin_d   = max_bin_q;
    max_count_d = max_count_q;
    max_vld_d   = 1'b0;

    if (enable) begin
      s1_vld_d = accept && beat_ok;
      s1_idx_d = beat_idx[AW-1:0];
      s2_vld_d = s1_vld_q;
      s2_idx_d = s1_idx_q;
      s2_cnt_d = rd_fwd;

      if (s3_bump) begin
        max_bin_d   = (BIN_W-1)'(s2_idx_q);
        max_count_d = s3_cnt;
        max_vld_d   = 1'b1;
      end

      unique case (state_q)
        StClear: begin
          max_bin_d   = '0;
          max_count_d = '0;
          clr_addr_d  = clr_addr_q + AW'(1);
          if (clr_addr_q == AW'(NBINS - 1)) begin
            clr_addr_d = '0;
            state_d    = StAccum;
          end
        end
        StAccum: begin
          if (event_done) state_d = StDrain;
        end
        StDrain: begin
          if (!s1_vld_q && !s2_vld_q) state_d = StReport;
        end
        StReport: begin
          if (AUTO_CLEAR) begin
            state_d = StClear;
          end else begin
            state_d     = StAccum;
            max_bin_d   = '0;
            max_count_d = '0;
          end
        end
        default: state_d = StClear;
      endcase

      // Abort: flush in-flight beats and restart the sweep from bin 0.
      if (clear_req) begin
        state_d     = StClear;
        clr_addr_d  = '0;
        s1_vld_d    = 1'b0;
        s2_vld_d    = 1'b0;
        max_bin_d   = '0;
        max_count_d = '0;
        max_vld_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      clr_addr_q  <= '0;
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_idx_q    <= '0;
      s2_cnt_q    <= '0;
      max_bin_q   <= '0;
      max_count_q <= '0;
      max_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      s1_vld_q    <= s1_vld_d;
      s1_idx_q    <= s1_idx_d;
      s2_vld_q    <= s2_vld_d;
      s2_idx_q    <= s2_idx_d;
      s2_cnt_q    <= s2_cnt_d;
      max_bin_q   <= max_bin_d;
      max_count_q <= max_count_d;
      max_vld_q   <= max_vld_d;
    end
  end

  // Bin storage has no reset; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (enable && (state_q == StClear)) begin
      mem[clr_addr_q] <= '0;
    end else if (s3_we) begin
      mem[s2_idx_q] <= s3_cnt;
    end
  end

  assign bin_if.bin_tready = (state_q == StAccum) && enable;
  assign clear_busy        = (state_q == StClear);
  assign max_bin           = max_bin_q;
  assign max_count         = max_count_q;
  assign max_vld           = max_vld_q && enable;
  assign result_vld        = (state_q == StReport) && enable && !clear_req;
  assign result_bin        = max_bin_q;
  assign result_count      = max_count_q;

endmodule
